// File: rtl/calculator_muehlbb_pkg.sv
// Shared constants for the calculator tile: opcodes, control-pin indices, flag positions.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int UIO_LOAD_A  = 3;
    localparam int UIO_LOAD_B  = 4;
    localparam int UIO_EXEC    = 5;
    localparam int UIO_SHOW_HI = 6;

    localparam int FLAG_CARRY = 7;
    localparam int FLAG_ZERO  = 6;

    localparam logic [7:0] UIO_OE_VALUE = 8'hC0;

endpackage

// File: rtl/calculator_muehlbb_if.sv
// TinyTapeout-style pin bundle for the calculator tile.
interface calculator_muehlbb_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/calculator_muehlbb_alu.sv
// Combinational 8-bit ALU. Multiply is only built when CALC_MUL_EN is defined;
// otherwise opcode 111 returns all zeros.
module calc_alu
    import calc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] res,
    output logic [7:0] hi,
    output logic       carry
);

    logic [8:0]  sum;
    logic [15:0] shl;
    logic [15:0] shr;

    always_comb begin
        res   = 8'h00;
        hi    = 8'h00;
        carry = 1'b0;
        sum   = 9'h000;
        // Widened shifts keep the last bit shifted out at a fixed position
        shl   = {8'h00, a} << b[2:0];
        shr   = {a, 8'h00} >> b[2:0];
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                res   = sum[7:0];
                carry = sum[8];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res   = shl[7:0];
                carry = shl[8];
            end
            OP_SHR: begin
                res   = shr[15:8];
                carry = shr[7];
            end
            OP_MUL: begin
`ifdef CALC_MUL_EN
                {hi, res} = a * b;
                carry     = (hi != 8'h00);
`else
                res   = 8'h00;
                hi    = 8'h00;
                carry = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calculator_muehlbb.sv
// Register-based calculator tile: strobe edge detection, operand/result/flag
// registers and display mux. Optional multiply via CALC_MUL_EN (see calc_alu).
module calculator_muehlbb
    import calc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    calculator_muehlbb_if.slave         bus
);

    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] res_q, res_d;
    logic [7:0] hi_q, hi_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    // {exec, load_b, load_a} as sampled on the previous edge
    logic [2:0] hist_q, hist_d;

    logic [2:0] strobe_now;
    logic [2:0] fire;
    logic [7:0] alu_res;
    logic [7:0] alu_hi;
    logic       alu_carry;
    logic       unused_uio;

    assign unused_uio = bus.uio_in[7];

    assign strobe_now = {bus.uio_in[UIO_EXEC], bus.uio_in[UIO_LOAD_B], bus.uio_in[UIO_LOAD_A]};
    assign fire       = strobe_now & ~hist_q & {3{bus.ena}};

    calc_alu u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (bus.uio_in[2:0]),
        .res   (alu_res),
        .hi    (alu_hi),
        .carry (alu_carry)
    );

    always_comb begin
        hist_d  = strobe_now;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (fire[0]) a_d = bus.ui_in;
        if (fire[1]) b_d = bus.ui_in;
        // ALU reads the registered operands, so a same-edge load is not seen
        if (fire[2]) begin
            res_d   = alu_res;
            hi_d    = alu_hi;
            carry_d = alu_carry;
            zero_d  = (alu_res == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= 3'b111;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 8'h00;
            hi_q    <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        bus.uo_out                 = bus.uio_in[UIO_SHOW_HI] ? hi_q : res_q;
        bus.uio_out                = 8'h00;
        bus.uio_out[FLAG_CARRY]    = carry_q;
        bus.uio_out[FLAG_ZERO]     = zero_q;
        bus.uio_oe                 = UIO_OE_VALUE;
    end

endmodule

// File: tb/tb_calculator_muehlbb.sv
// Directed self-checking bench for calculator_muehlbb (covers both CALC_MUL_EN builds).
module tb_calculator_muehlbb;
    import calc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    calculator_muehlbb_if bus ();

    calculator_muehlbb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        bus.ui_in = v;
        bus.uio_in[UIO_LOAD_A] = 1'b1;
        tick();
        bus.uio_in[UIO_LOAD_A] = 1'b0;
        tick();
    endtask

    task automatic load_b(input logic [7:0] v);
        bus.ui_in = v;
        bus.uio_in[UIO_LOAD_B] = 1'b1;
        tick();
        bus.uio_in[UIO_LOAD_B] = 1'b0;
        tick();
    endtask

    task automatic exec(input logic [2:0] op);
        bus.uio_in[2:0] = op;
        bus.uio_in[UIO_EXEC] = 1'b1;
        tick();
        bus.uio_in[UIO_EXEC] = 1'b0;
        tick();
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        load_a(a);
        load_b(b);
        exec(op);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'hAA;
        bus.uio_in = 8'h00;
        bus.uio_in[UIO_LOAD_A] = 1'b1;
        #22;
        chk("rst_uo_out", {8'h0, bus.uo_out}, 16'h0000);
        chk("rst_uio_out", {8'h0, bus.uio_out}, 16'h0000);
        chk("uio_oe", {8'h0, bus.uio_oe}, 16'h00C0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("held_strobe_uo", {8'h0, bus.uo_out}, 16'h0000);
        bus.uio_in[UIO_LOAD_A] = 1'b0;
        tick();
        // A must still be 0 if the held strobe was ignored: A|B = 0
        exec(OP_OR);
        chk("held_strobe_a", {8'h0, bus.uo_out}, 16'h0000);
        chk("held_strobe_zf", {15'h0, bus.uio_out[FLAG_ZERO]}, 16'h0001);

        run(8'd200, 8'd100, OP_ADD);
        chk("add_res", {8'h0, bus.uo_out}, 16'd44);
        chk("add_flags", {8'h0, bus.uio_out}, 16'h0080);

        run(8'd5, 8'd5, OP_SUB);
        chk("sub_zero_res", {8'h0, bus.uo_out}, 16'd0);
        chk("sub_zero_flags", {8'h0, bus.uio_out}, 16'h0040);
        run(8'd3, 8'd5, OP_SUB);
        chk("sub_borrow_res", {8'h0, bus.uo_out}, 16'd254);
        chk("sub_borrow_flags", {8'h0, bus.uio_out}, 16'h0080);

        run(8'h81, 8'd1, OP_SHL);
        chk("shl_res", {8'h0, bus.uo_out}, 16'h0002);
        chk("shl_c", {15'h0, bus.uio_out[FLAG_CARRY]}, 16'h0001);
        exec(OP_SHR);
        chk("shr_res", {8'h0, bus.uo_out}, 16'h0040);
        chk("shr_c", {15'h0, bus.uio_out[FLAG_CARRY]}, 16'h0001);
        run(8'h81, 8'd0, OP_SHL);
        chk("shl0_res", {8'h0, bus.uo_out}, 16'h0081);
        chk("shl0_c", {15'h0, bus.uio_out[FLAG_CARRY]}, 16'h0000);

        run(8'hF0, 8'h3C, OP_AND);
        chk("and_res", {8'h0, bus.uo_out}, 16'h0030);
        exec(OP_XOR);
        chk("xor_res", {8'h0, bus.uo_out}, 16'h00CC);
        chk("xor_c", {15'h0, bus.uio_out[FLAG_CARRY]}, 16'h0000);

        run(8'd20, 8'd20, OP_MUL);
`ifdef CALC_MUL_EN
        chk("mul_lo", {8'h0, bus.uo_out}, 16'h0090);
        chk("mul_flags", {8'h0, bus.uio_out}, 16'h0080);
        bus.uio_in[UIO_SHOW_HI] = 1'b1;
        #1;
        chk("mul_hi", {8'h0, bus.uo_out}, 16'h0001);
`else
        chk("mul_lo", {8'h0, bus.uo_out}, 16'h0000);
        chk("mul_flags", {8'h0, bus.uio_out}, 16'h0040);
        bus.uio_in[UIO_SHOW_HI] = 1'b1;
        #1;
        chk("mul_hi", {8'h0, bus.uo_out}, 16'h0000);
`endif
        bus.uio_in[UIO_SHOW_HI] = 1'b0;

        run(8'd7, 8'd1, OP_ADD);
        chk("pre_ena_res", {8'h0, bus.uo_out}, 16'd8);
        bus.ena = 1'b0;
        bus.ui_in = 8'd99;
        bus.uio_in[UIO_LOAD_A] = 1'b1;
        tick();
        bus.uio_in[2:0] = OP_OR;
        bus.uio_in[UIO_EXEC] = 1'b1;
        tick();
        chk("ena_low_hold", {8'h0, bus.uo_out}, 16'd8);
        bus.uio_in[UIO_LOAD_A] = 1'b0;
        bus.uio_in[UIO_EXEC] = 1'b0;
        tick();
        bus.ena = 1'b1;
        exec(OP_ADD);
        chk("ena_low_a_kept", {8'h0, bus.uo_out}, 16'd8);

        // LOAD_B and EXEC on the same edge: OR uses old B (1), giving 7
        bus.ui_in = 8'd50;
        bus.uio_in[2:0] = OP_OR;
        bus.uio_in[UIO_LOAD_B] = 1'b1;
        bus.uio_in[UIO_EXEC] = 1'b1;
        tick();
        bus.uio_in[UIO_LOAD_B] = 1'b0;
        bus.uio_in[UIO_EXEC] = 1'b0;
        tick();
        chk("same_cycle_old_b", {8'h0, bus.uo_out}, 16'd7);
        exec(OP_OR);
        chk("new_b_after", {8'h0, bus.uo_out}, 16'd55);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
